// File: rtl/dense_layer_sequencer.sv
// dense_layer_sequencer
//   Control FSM that time-shares one dense-layer MAC datapath (multiplier,
//   accumulator, weight scale, activation LUT) across layers of different
//   shape. For each neuron it loads the bias, streams weight and input
//   addresses, waits for the MAC pipeline to drain and then hands the
//   result to the activation stage over a valid/ready handshake.
//
//   Optional feature macro: DENSE_SEQ_PERF_EN adds perf_cycles, a saturating
//   count of busy cycles for the most recent run.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start           start request, sampled only while idle
//   cfg_nb_input    input count (1..MAX_IN)
//   cfg_nb_neurons  neuron count (1..MAX_NEU)
//   cfg_stride      weight row stride (weight addr = in*stride + neu)
//   bias_addr       bias index of the current neuron
//   mac_clr         load bias into the accumulator
//   mac_en          accumulate w[w_addr] * x[in_addr]
//   w_addr, in_addr weight / input addresses
//   out_valid       result ready for the activation stage
//   out_ready       activation stage accepts the result
//   out_idx         neuron index of the presented result
//   busy            high from the first bias load through the done cycle
//   done            one-cycle completion pulse
//   err             high with done when the config was rejected
//   perf_cycles     busy-cycle counter (DENSE_SEQ_PERF_EN only)
module dense_layer_sequencer #(
  parameter int unsigned MAX_IN  = 96,
  parameter int unsigned MAX_NEU = 24,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned MAC_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [6:0]        cfg_nb_input,
  input  logic [4:0]        cfg_nb_neurons,
  input  logic [4:0]        cfg_stride,
  output logic [4:0]        bias_addr,
  output logic              mac_clr,
  output logic              mac_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic [6:0]        in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_idx,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef DENSE_SEQ_PERF_EN
  ,
  output logic [15:0]       perf_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIAS,
    S_MAC,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [6:0] MAX_IN_C  = 7'(MAX_IN);
  localparam logic [4:0] MAX_NEU_C = 5'(MAX_NEU);
  // Drain counter preload; counts down to zero so DRAIN lasts MAC_LAT cycles.
  localparam logic [2:0] LAT_M1    = (MAC_LAT == 0) ? 3'd0 : 3'(MAC_LAT - 1);

  state_t     state;
  logic [4:0] neu;
  logic [6:0] nin_q;
  logic [4:0] nneu_q;
  logic [4:0] stride_q;
  logic [2:0] drain_cnt;
  logic       cfg_invalid;

  always_comb begin
    cfg_invalid = (cfg_nb_input == '0) || (cfg_nb_neurons == '0) ||
                  (cfg_nb_input > MAX_IN_C) || (cfg_nb_neurons > MAX_NEU_C);
  end

  // in_addr and w_addr double as the input index and running weight base,
  // so the address stream is a pure add-stride walk with no multiplier.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      neu       <= '0;
      nin_q     <= '0;
      nneu_q    <= '0;
      stride_q  <= '0;
      drain_cnt <= '0;
      bias_addr <= '0;
      mac_clr   <= 1'b0;
      mac_en    <= 1'b0;
      w_addr    <= '0;
      in_addr   <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            nin_q    <= cfg_nb_input;
            nneu_q   <= cfg_nb_neurons;
            stride_q <= cfg_stride;
            neu      <= '0;
            if (cfg_invalid) begin
              state <= S_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state     <= S_BIAS;
              busy      <= 1'b1;
              mac_clr   <= 1'b1;
              bias_addr <= '0;
            end
          end
        end

        S_BIAS: begin
          mac_clr <= 1'b0;
          mac_en  <= 1'b1;
          in_addr <= '0;
          w_addr  <= ADDR_W'(neu);
          state   <= S_MAC;
        end

        S_MAC: begin
          if (in_addr == nin_q - 7'd1) begin
            mac_en <= 1'b0;
            if (MAC_LAT == 0) begin
              state     <= S_WRITE;
              out_valid <= 1'b1;
              out_idx   <= neu;
            end else begin
              state     <= S_DRAIN;
              drain_cnt <= LAT_M1;
            end
          end else begin
            in_addr <= in_addr + 7'd1;
            w_addr  <= w_addr + ADDR_W'(stride_q);
          end
        end

        S_DRAIN: begin
          if (drain_cnt == '0) begin
            state     <= S_WRITE;
            out_valid <= 1'b1;
            out_idx   <= neu;
          end else begin
            drain_cnt <= drain_cnt - 3'd1;
          end
        end

        S_WRITE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (neu == nneu_q - 5'd1) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              neu       <= neu + 5'd1;
              bias_addr <= neu + 5'd1;
              mac_clr   <= 1'b1;
              state     <= S_BIAS;
            end
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DENSE_SEQ_PERF_EN
  // Counts the registered busy flag, so the final value lands one cycle
  // after done and then holds until the next start.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles <= '0;
    end else if (state == S_IDLE && start) begin
      perf_cycles <= '0;
    end else if (busy && perf_cycles != '1) begin
      perf_cycles <= perf_cycles + 16'd1;
    end
  end
`endif

endmodule
